// File: rtl/zx_video_pkg.sv
// zx_video_pkg: shared definitions for the ZX video path.
//   ZX_LINE_LEN  - ULA pixels per scanline
//   ZX_HS_LEN    - VGA hsync width in clk14 cycles
//   rgbi_t       - one ULA pixel, {i, r, g, b}
//   rgbi_to_dac  - one colour gun plus bright bit to a 2-bit resistor-DAC level
package zx_video_pkg;

  localparam int unsigned ZX_LINE_LEN = 448;
  localparam int unsigned ZX_HS_LEN   = 54;

  typedef struct packed {
    logic i;
    logic r;
    logic g;
    logic b;
  } rgbi_t;

  // Gun off -> black; gun on -> 2'b10, or full scale 2'b11 when bright.
  function automatic logic [1:0] rgbi_to_dac(input logic gun, input logic bright);
    return gun ? {1'b1, bright} : 2'b00;
  endfunction

endpackage

// File: rtl/zx_linebuf.sv
// zx_linebuf: ping-pong scanline store, 2 banks x 2^AW entries of rgbi_t.
// Simple dual-port: one write port, one synchronous read port. The bank select is
// the address MSB so the whole array maps onto a single block RAM.
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - {bank, address} to write
//   wdata_i  - pixel to write
//   raddr_i  - {bank, address} to read
//   rdata_o  - pixel read, valid one cycle after raddr_i
module zx_linebuf
  import zx_video_pkg::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [AW:0] waddr_i,
  input  rgbi_t       wdata_i,
  input  logic [AW:0] raddr_i,
  output rgbi_t       rdata_o
);

  rgbi_t mem_q [2**(AW+1)];
  rgbi_t rdata_q;

  // No reset: contents are don't-care until a full line has been written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zx_scandoubler.sv
// zx_scandoubler: converts the 15.6 kHz ULA RGBI stream into 31.2 kHz VGA by writing
// each input line into one bank of a ping-pong buffer at the ce7 pixel rate and
// replaying the other bank twice at the full clk14 rate.
//   clk14              - 14 MHz clock, the only clock
//   rst                - synchronous active-high reset
//   ce7                - pixel enable, one clk14 cycle in two
//   ri, gi, bi, ii     - ULA colour and bright, already blanked
//   hsync_in_n         - ULA hsync, active-low; its falling edge starts a new line
//   vsync_in_n         - ULA vsync, active-low
//   vga_r/vga_g/vga_b  - 2-bit DAC colour, registered
//   vga_hs_n/vga_vs_n  - VGA syncs, active-low, aligned with the colour pipeline
// Build option: define ZX_SCANLINES_EN to dim the second copy of each line.
module zx_scandoubler
  import zx_video_pkg::*;
#(
  parameter int unsigned LINE_LEN = ZX_LINE_LEN,
  parameter int unsigned HS_LEN   = ZX_HS_LEN,
  parameter int unsigned AW       = 9
) (
  input  logic       clk14,
  input  logic       rst,
  input  logic       ce7,
  input  logic       ri,
  input  logic       gi,
  input  logic       bi,
  input  logic       ii,
  input  logic       hsync_in_n,
  input  logic       vsync_in_n,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hs_n,
  output logic       vga_vs_n
);

`ifdef ZX_SCANLINES_EN
  localparam bit ScanlinesEn = 1'b1;
`else
  localparam bit ScanlinesEn = 1'b0;
`endif

  localparam logic [AW-1:0] RdLast = AW'(LINE_LEN - 1);
  localparam logic [AW-1:0] HsEnd  = AW'(HS_LEN);
  localparam logic [AW-1:0] WrMax  = '1;

  // Input sampling and line-start detect
  logic hs_prev_q, vs_smp_q;
  logic hs_fall;

  assign hs_fall = ce7 & ~hsync_in_n & hs_prev_q;

  // Write/read pointers
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_line_q, rd_line_d;
  logic          valid_q, valid_d;

  always_comb begin
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q + AW'(1);
    rd_line_d = rd_line_q;
    valid_d   = valid_q;

    if (rd_addr_q == RdLast) begin
      rd_addr_d = '0;
      rd_line_d = ~rd_line_q;
    end

    // Resync overrides the read wrap; the edge pixel itself lands at address 0.
    if (hs_fall) begin
      wbank_d   = ~wbank_q;
      rbank_d   = wbank_q;
      wr_addr_d = AW'(1);
      rd_addr_d = '0;
      rd_line_d = 1'b0;
      valid_d   = 1'b1;
    end else if (ce7 && (wr_addr_q != WrMax)) begin
      wr_addr_d = wr_addr_q + AW'(1);
    end
  end

  // Line buffer
  logic [AW-1:0] wr_ptr;
  rgbi_t         wr_pix, rd_pix;

  assign wr_ptr = hs_fall ? '0 : wr_addr_q;
  assign wr_pix = '{i: ii, r: ri, g: gi, b: bi};

  zx_linebuf #(
    .AW(AW)
  ) u_linebuf (
    .clk_i  (clk14),
    .we_i   (ce7 & ~rst),
    .waddr_i({wbank_d, wr_ptr}),
    .wdata_i(wr_pix),
    .raddr_i({rbank_q, rd_addr_q}),
    .rdata_o(rd_pix)
  );

  // Stage 1 runs alongside the RAM read; stage 2 is the output register.
  logic line_p_q, valid_p_q;
  logic hs_p_q, vs_hold_q;
  logic hs_raw, vs_raw;

  assign hs_raw = (rd_addr_q >= HsEnd);
  // vsync is only allowed to change at the start of an output line.
  assign vs_raw = (rd_addr_q == '0) ? vs_smp_q : vs_hold_q;

  logic [1:0] r_d, g_d, b_d;

  always_comb begin
    r_d = 2'b00;
    g_d = 2'b00;
    b_d = 2'b00;
    if (valid_p_q) begin
      r_d = rgbi_to_dac(rd_pix.r, rd_pix.i);
      g_d = rgbi_to_dac(rd_pix.g, rd_pix.i);
      b_d = rgbi_to_dac(rd_pix.b, rd_pix.i);
      if (ScanlinesEn && line_p_q) begin
        r_d = r_d >> 1;
        g_d = g_d >> 1;
        b_d = b_d >> 1;
      end
    end
  end

  always_ff @(posedge clk14) begin
    if (rst) begin
      hs_prev_q <= 1'b1;
      vs_smp_q  <= 1'b1;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b1;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_line_q <= 1'b0;
      valid_q   <= 1'b0;
      line_p_q  <= 1'b0;
      valid_p_q <= 1'b0;
      hs_p_q    <= 1'b1;
      vs_hold_q <= 1'b1;
      vga_r     <= 2'b00;
      vga_g     <= 2'b00;
      vga_b     <= 2'b00;
      vga_hs_n  <= 1'b1;
      vga_vs_n  <= 1'b1;
    end else begin
      if (ce7) begin
        hs_prev_q <= hsync_in_n;
        vs_smp_q  <= vsync_in_n;
      end
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_line_q <= rd_line_d;
      valid_q   <= valid_d;
      line_p_q  <= rd_line_q;
      valid_p_q <= valid_q;
      hs_p_q    <= hs_raw;
      vs_hold_q <= vs_raw;
      vga_r     <= r_d;
      vga_g     <= g_d;
      vga_b     <= b_d;
      vga_hs_n  <= hs_p_q;
      vga_vs_n  <= vs_hold_q;
    end
  end

endmodule

// File: doc/zx_scandoubler.md
# zx_scandoubler

Downstream video stage for the ULA. It takes the 15.6 kHz PAL-timed RGBI pixel stream and separate syncs from the ULA, and writes each scanline into a ping-pong line buffer at the 7 MHz pixel rate. It reads each buffered line out twice at 14 MHz, producing a 31.2 kHz VGA-compatible signal with 2-bit-per-gun colour for the board's resistor DAC. The block runs entirely on `clk14`, with the ULA pixel rate supplied as a clock enable.

## Interface
Parameters:
- `LINE_LEN`, 448: pixels per input line; read-address wrap point.
- `HS_LEN`, 54: output hsync width in `clk14` cycles (≈3.8 µs).
- `AW`, 9: line-buffer address width per bank.

Ports:
- `clk14`  in  1  14 MHz master clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce7`  in  1  pixel enable, high on one `clk14` cycle in two (ULA `clk7` rate).
- `ri`, `gi`, `bi`, `ii`  in  1 each  ULA colour and bright, already blanked.
- `hsync_in_n`  in  1  ULA hsync, active-low.
- `vsync_in_n`  in  1  ULA vsync, active-low.
- `vga_r`, `vga_g`, `vga_b`  out  2 each  DAC colour.
- `vga_hs_n`  out  1  output hsync, active-low.
- `vga_vs_n`  out  1  output vsync, active-low.

## Operation
Input sampling:
- All inputs are sampled only on `ce7`.
- An input hsync fall is detected as `hsync_in_n`=0 while the previous sampled value was 1.

Write side:
- On each `ce7`, pixel {i,r,g,b} is written to `bank[wbank][wr_addr]`, then `wr_addr` increments.
- `wr_addr` saturates at 2^AW−1 and does not wrap.
- On an input hsync fall, in the same cycle:
  - `wbank` toggles.
  - `wr_addr` is set to 0 (the falling-edge pixel is written at address 0).
  - `rbank` is set to the old `wbank`.
  - `rd_addr` is set to 0 and `rd_line` to 0.
  - `valid` is set to 1.

Read side:
- `rd_addr` advances every `clk14` cycle.
- At `LINE_LEN`−1, `rd_addr` wraps to 0 and `rd_line` toggles. The same bank is replayed, giving two output lines per input line.
- If no input hsync arrives, the read side free-runs, replaying `rbank` indefinitely.
- A hsync fall always resyncs immediately, truncating the current output line.

Output sync:
- Raw output hsync is low while `rd_addr` < `HS_LEN`.
- Raw output vsync is `vsync_in_n`, captured whenever `rd_addr`=0.

Colour conversion, per gun:
- Gun 0 gives 2'b00.
- Gun 1 with `i`=0 gives 2'b10.
- Gun 1 with `i`=1 gives 2'b11.
- The conversion function lives in the shared package.

Until `valid`=1, colour outputs are forced to 0. Syncs still run.

## Timing
- Reset values: `vga_r`/`vga_g`/`vga_b`=0, `vga_hs_n`=1, `vga_vs_n`=1.
- Reset state: `wbank`=0, `rbank`=1, `wr_addr`=0, `rd_addr`=0, `rd_line`=0, `valid`=0.
- Line-buffer contents are not reset.
- Read pipeline: address at cycle n, synchronous RAM data at n+1, registered colour at n+2.
- Hsync and vsync are delayed through 2 matching stages, so sync and colour stay aligned.
- Input-to-output latency: a pixel written at input address k appears on output line 0 at `rd_addr`=k+2 cycles after that line's hsync fall. Output line 0 starts 1 `clk14` after the input hsync fall.
- Nominal frame: an input line is 896 `clk14` cycles, exactly two output lines of 448, so resync causes no truncation.
- Simultaneous hsync fall and `rd_addr` wrap: the resync wins.
- `rst` asserted mid-line: all state returns to reset values on the next edge. No output glitch beyond the forced values.

## Configuration
- Macro `ZX_SCANLINES_EN`.
- When defined: output line `rd_line`=1 is dimmed. Each gun's 2-bit value is shifted right by 1 (11→01, 10→01, 00→00).
- When undefined: both output lines are identical.
- Syncs and timing are unaffected either way.

## Structure
- Package `zx_video_pkg`:
  - constants `ZX_LINE_LEN`=448 and `ZX_HS_LEN`=54.
  - typedef `rgbi_t` (4-bit, {i,r,g,b}).
  - function `rgbi_to_dac` (gun, bright → 2 bits).
- Sub-module `zx_linebuf`: simple dual-port 2×2^AW × 4-bit RAM, synchronous read, one write port and one read port, with bank select as the address MSB. It is kept separate so it can infer block RAM.
- The top level holds the counters, edge detect, sync pipeline and colour conversion.

## Test plan
- **Reset:** hold `rst` for 4 cycles with inputs toggling -> all outputs at reset values; colour stays 0 until the first `hsync_in_n` fall.
- **Doubling:** drive a 448-pixel line with pixel k = k mod 16, blue=1, bright=1 at k=10 -> output lines 0 and 1 both show `vga_b`=2'b11 at `rd_addr` 12, and exactly 896 `clk14` cycles elapse between input hsync falls.
- **Output hsync:** with periodic input lines -> `vga_hs_n` is low for exactly 54 cycles starting 3 cycles after each input hsync fall, with a second pulse 448 cycles later.
- **Missing hsync:** suppress one input hsync -> the read side replays the previous bank for 4 total output lines; `wr_addr` saturates at 511 with no wrap; the next hsync fall restarts at `rd_line`=0.
- **Scanlines:** with `ZX_SCANLINES_EN` defined and pixel white bright -> line 0 = 2'b11 on all guns, line 1 = 2'b01. With the macro undefined -> both lines = 2'b11.
- **Vsync alignment:** assert `vsync_in_n` low for 4 input lines -> `vga_vs_n` is low for exactly 8 output lines, changing only 2 cycles after `rd_addr`=0.
